pe_result_writer: RTL and testbench
===================================

Name: pe_result_writer

Overview:
Write-back initiator for the on-chip buffer. It captures one flattened 3x3 PE result snapshot on a start pulse, then serializes it into single-word buffer writes at consecutive addresses from a base address. It drives the buffer's address, write-data and write-enable inputs, which is the write side of the path that feeds the PE array. A ready input throttles writes, so the buffer port can be shared with the read sequencer.

Parameters:
ADDR_BITS, 8, buffer address width
DATA_BITS, 6, buffer word width (must be >= RES_BITS)
PE_ROWS, 3, PE array rows
PE_COLS, 3, PE array columns
RES_BITS, 2, width of one PE result, two's complement

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  capture request, sampled in IDLE only
base_addr  input  ADDR_BITS  first write address, latched with start
results_in  input  PE_ROWS*PE_COLS*RES_BITS  PE outputs; element idx=row*PE_COLS+col at bits [idx*RES_BITS +: RES_BITS]
buf_ready  input  1  buffer port granted this cycle
addr_out  output  ADDR_BITS  buffer write address
data_out  output  DATA_BITS  buffer write data
write_enable  output  1  buffer write strobe, one word per high cycle
busy  output  1  high in WRITE and DONE
done  output  1  one-cycle pulse after the last write

Behaviour:
- Clocking and reset: one clock domain (clk). Asynchronous, active-high reset: state goes to IDLE, idx=0, latched snapshot and base cleared, and addr_out, data_out, write_enable, busy and done all go to 0.
- All outputs are registered. N = PE_ROWS*PE_COLS.
- States and transitions:
  - IDLE: if start=1 at an edge, latch results_in and base_addr, set idx=0 and go to WRITE. busy rises at that edge.
  - WRITE, edge with buf_ready=1: write_enable<=1, addr_out<=(base+idx) mod 2^ADDR_BITS, data_out<=conv(elem[idx]), idx<=idx+1. If idx was N-1, go to DONE.
  - WRITE, edge with buf_ready=0: write_enable<=0. addr_out and data_out hold. idx holds.
  - DONE: write_enable<=0, done<=1 for exactly one cycle, busy<=0, then IDLE.
- Write order: element 0 to N-1, each exactly once.
- conv(): sign-extend RES_BITS to DATA_BITS (see Optional Feature).
- Latency: with buf_ready held high, the first write_enable is visible the cycle after the start edge. There are N consecutive write cycles. done is high in cycle N+1 after start, and busy is low from cycle N+2.
- Boundary conditions:
  - start while busy (WRITE or DONE) is ignored. The snapshot is not re-latched and no error is raised.
  - start in the same cycle done is high is also ignored. start is accepted the next cycle once state is IDLE.
  - Address wrap: base+idx overflow wraps modulo 2^ADDR_BITS with no flag.
  - buf_ready is ignored outside WRITE.
  - Reset mid-WRITE takes effect immediately: write_enable drops asynchronously, no further writes are issued, and the snapshot is discarded. No done pulse.
  - results_in changing after start has no effect on the written data.

Optional Feature:
PE_WRITER_RELU_EN
- Defined: conv() applies ReLU. Elements with MSB=1 are written as 0. Non-negative elements are zero-extended.
- Undefined: conv() is plain sign extension to DATA_BITS.
- Handshake and timing are identical in both builds.

Test Plan:
- Basic drain: reset, buf_ready=1, base_addr=8'h10, elements 0..8 = {0,1,2,3,0,1,2,3,1}, start pulse -> writes at addresses 0x10..0x18 on 9 consecutive cycles, data {0,1,2,3,0,1,2,3,1} sign-extended (elements 2,3 give 6'h3E,6'h3F), then done=1 for 1 cycle, then busy=0.
- Backpressure: buf_ready toggles 1,0,0,1,... with base=0 -> exactly 9 write_enable pulses at addresses 0..8 in order, no duplicates, and addr/data hold during ready=0 cycles.
- Wrap: base_addr=8'hFC -> addresses FC,FD,FE,FF,00,01,02,03,04.
- Busy start: second start during WRITE with different results_in -> written data still matches the first snapshot, and no second drain follows.
- Reset mid-op: assert reset after the 4th write -> write_enable, busy and done go to 0 immediately; no done pulse; a fresh start afterwards drains all 9 words.
- RELU build: elements {3,2,1,0,...} with PE_WRITER_RELU_EN defined -> data {0,0,1,0,...}; without the macro -> {3F,3E,01,00,...}.

Source files
------------

// File: rtl/pe_result_writer.sv
// Captures a PE result snapshot on start and writes it to the buffer, one word per granted cycle.
// Optional build macro PE_WRITER_RELU_EN: negative results are written as zero instead of sign-extended.
module pe_result_writer #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 6,
   parameter int PE_ROWS   = 3,
   parameter int PE_COLS   = 3,
   parameter int RES_BITS  = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [ADDR_BITS-1:0]                base_addr,
   input  logic [PE_ROWS*PE_COLS*RES_BITS-1:0] results_in,
   input  logic                                buf_ready,
   output logic [ADDR_BITS-1:0]                addr_out,
   output logic [DATA_BITS-1:0]                data_out,
   output logic                                write_enable,
   output logic                                busy,
   output logic                                done
);

   localparam int N        = PE_ROWS * PE_COLS;
   localparam int IDX_BITS = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                      state, state_nxt;
   logic [IDX_BITS-1:0]         idx, idx_nxt;
   logic [N*RES_BITS-1:0]       snap, snap_nxt;
   logic [ADDR_BITS-1:0]        base, base_nxt;
   logic [ADDR_BITS-1:0]        addr_nxt;
   logic [DATA_BITS-1:0]        data_nxt;
   logic                        we_nxt, busy_nxt, done_nxt;
   logic [RES_BITS-1:0]         elem;

   function automatic logic [DATA_BITS-1:0] conv(input logic [RES_BITS-1:0] e);
`ifdef PE_WRITER_RELU_EN
      conv = e[RES_BITS-1] ? '0 : DATA_BITS'(e);
`else
      conv = DATA_BITS'($signed(e));
`endif
   endfunction

   assign elem = snap[idx*RES_BITS +: RES_BITS];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         idx          <= '0;
         snap         <= '0;
         base         <= '0;
         addr_out     <= '0;
         data_out     <= '0;
         write_enable <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         snap         <= snap_nxt;
         base         <= base_nxt;
         addr_out     <= addr_nxt;
         data_out     <= data_nxt;
         write_enable <= we_nxt;
         busy         <= busy_nxt;
         done         <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      snap_nxt  = snap;
      base_nxt  = base;
      addr_nxt  = addr_out;
      data_nxt  = data_out;
      we_nxt    = 1'b0;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            busy_nxt = 1'b0;
            // busy covers the done cycle too, so a start seen alongside done is dropped
            if (start && !done) begin
               snap_nxt  = results_in;
               base_nxt  = base_addr;
               idx_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            if (buf_ready) begin
               we_nxt   = 1'b1;
               addr_nxt = base + ADDR_BITS'(idx);
               data_nxt = conv(elem);
               idx_nxt  = idx + IDX_BITS'(1);
               if (idx == IDX_BITS'(N - 1))
                  state_nxt = DONE;
            end
         end
         DONE: begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pe_result_writer.sv
// Directed bench for pe_result_writer: drains, backpressure, wrap, ignored starts, reset mid-drain, conv.
module tb_pe_result_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [17:0] results_in;
   logic        buf_ready;
   logic [7:0]  addr_out;
   logic [5:0]  data_out;
   logic        write_enable;
   logic        busy;
   logic        done;

   int          vectors = 0;
   int          miscompares = 0;
   logic [13:0] exp_q[$];
   logic [7:0]  obs_addr[9];
   logic [5:0]  obs_data[9];
   int          done_step;
   int          wcnt;

   // elements e8..e0; e0..e8 = {0,1,2,3,0,1,2,3,1}
   localparam logic [17:0] R_BASIC = {2'd1, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
   // e0..e8 = {3,2,1,0,3,2,1,0,2}
   localparam logic [17:0] R_CONV  = {2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
   // e0..e8 = {1,1,0,3,2,2,3,0,1}
   localparam logic [17:0] R_MIX   = {2'd1, 2'd0, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1, 2'd1};

   pe_result_writer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .results_in   (results_in),
      .buf_ready    (buf_ready),
      .addr_out     (addr_out),
      .data_out     (data_out),
      .write_enable (write_enable),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] model_conv(input logic [1:0] e);
`ifdef PE_WRITER_RELU_EN
      model_conv = e[1] ? 6'd0 : {4'd0, e};
`else
      model_conv = {{4{e[1]}}, e};
`endif
   endfunction

   task automatic drain(input logic [7:0] base, input logic [17:0] res, input bit throttle,
                        input int restart_step, input bit start_at_done, output int dstep);
      logic       prev_ready;
      int         wr;
      int         last_step;
      bit         seen_done;
      logic [7:0] last_addr;
      logic [5:0] last_data;
      logic [13:0] e;
      for (int i = 0; i < 9; i++)
         exp_q.push_back({base + 8'(i), model_conv(res[i*2 +: 2])});
      @(negedge clk);
      results_in = res;
      base_addr  = base;
      start      = 1'b1;
      buf_ready  = 1'b1;
      wr = 0; last_step = -10; seen_done = 1'b0; prev_ready = 1'b0; dstep = -1;
      last_addr = '0; last_data = '0;
      for (int i = 1; i <= 60 && !seen_done; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == restart_step) begin
            start      = 1'b1;
            results_in = ~res;
            base_addr  = base + 8'h40;
         end
         check("busy_during_drain", busy, 1);
         check("write_enable", write_enable, prev_ready && (wr < 9));
         check("done_pulse", done, (wr == 9) && (last_step == i - 1));
         if (write_enable) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '1;
            check("addr_out", addr_out, e[13:6]);
            check("data_out", data_out, e[5:0]);
            if (wr < 9) begin
               obs_addr[wr] = addr_out;
               obs_data[wr] = data_out;
            end
            wr++;
            last_step = i;
            last_addr = addr_out;
            last_data = data_out;
         end else if (wr > 0) begin
            check("addr_hold", addr_out, last_addr);
            check("data_hold", data_out, last_data);
         end
         if (done) begin
            seen_done = 1'b1;
            dstep = i;
         end
         buf_ready  = throttle ? ((i - 1) % 3 == 0) : 1'b1;
         prev_ready = buf_ready;
         if (seen_done && start_at_done) start = 1'b1;
      end
      check("done_seen", seen_done, 1);
      check("write_count", wr, 9);
      check("queue_empty", exp_q.size(), 0);
      exp_q.delete();
      @(negedge clk);
      start = 1'b0;
      check("busy_after_done", busy, 0);
      check("done_one_cycle", done, 0);
      check("we_after_done", write_enable, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("idle_no_write", write_enable, 0);
         check("idle_not_busy", busy, 0);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; buf_ready = 1'b0; base_addr = '0; results_in = '0;
      @(negedge clk);
      check("reset_addr", addr_out, 0);
      check("reset_data", data_out, 0);
      check("reset_we", write_enable, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      @(negedge clk);
      reset = 1'b0;

      // basic drain with latency and hand-computed words
      drain(8'h10, R_BASIC, 1'b0, 0, 1'b0, done_step);
      check("latency_done_step", done_step, 11);
      check("basic_addr0", obs_addr[0], 8'h10);
      check("basic_addr8", obs_addr[8], 8'h18);
      check("basic_data0", obs_data[0], 6'h00);
`ifdef PE_WRITER_RELU_EN
      check("basic_data1", obs_data[1], 6'h01);
      check("basic_data2", obs_data[2], 6'h00);
      check("basic_data3", obs_data[3], 6'h00);
`else
      check("basic_data1", obs_data[1], 6'h01);
      check("basic_data2", obs_data[2], 6'h3E);
      check("basic_data3", obs_data[3], 6'h3F);
`endif

      // backpressure: ready 1,0,0,1,...
      drain(8'h00, R_MIX, 1'b1, 0, 1'b0, done_step);
      check("bp_addr0", obs_addr[0], 8'h00);
      check("bp_addr8", obs_addr[8], 8'h08);

      // address wrap
      drain(8'hFC, R_BASIC, 1'b0, 0, 1'b0, done_step);
      check("wrap_addr3", obs_addr[3], 8'hFF);
      check("wrap_addr4", obs_addr[4], 8'h00);
      check("wrap_addr8", obs_addr[8], 8'h04);

      // start during WRITE and during the done cycle are ignored
      drain(8'h30, R_MIX, 1'b0, 4, 1'b1, done_step);
      check("busy_start_addr8", obs_addr[8], 8'h38);

      // reset after the 4th write
      @(negedge clk);
      results_in = R_BASIC; base_addr = 8'h20; start = 1'b1; buf_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wcnt = 0;
      for (int i = 0; i < 20 && wcnt < 4; i++) begin
         @(negedge clk);
         if (write_enable) wcnt++;
      end
      check("rst_four_writes", wcnt, 4);
      reset = 1'b1;
      #1;
      check("rst_async_we", write_enable, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_done", done, 0);
      check("rst_async_addr", addr_out, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("rst_no_write", write_enable, 0);
         check("rst_no_done", done, 0);
      end
      drain(8'h20, R_BASIC, 1'b0, 0, 1'b0, done_step);
      check("rst_fresh_addr8", obs_addr[8], 8'h28);

      // conv vectors for {3,2,1,0,...}
      drain(8'h50, R_CONV, 1'b0, 0, 1'b0, done_step);
`ifdef PE_WRITER_RELU_EN
      check("conv_data0", obs_data[0], 6'h00);
      check("conv_data1", obs_data[1], 6'h00);
      check("conv_data2", obs_data[2], 6'h01);
      check("conv_data3", obs_data[3], 6'h00);
`else
      check("conv_data0", obs_data[0], 6'h3F);
      check("conv_data1", obs_data[1], 6'h3E);
      check("conv_data2", obs_data[2], 6'h01);
      check("conv_data3", obs_data[3], 6'h00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
